peatc_tx_arbiter: RTL and testbench
===================================

# peatc_tx_arbiter

Round-robin arbiter that shares one 32-bit FPGA-to-host FIFO write port between two 16-bit sample streams: GS raw-signal samples and RN diagnosis results. It sits between the GS/RN state machines and the host-bound FIFO, all on `bus_clk`. Each accepted sample becomes a tagged 32-bit word carrying the source, a last-of-record flag and a per-source sequence number, so the host can demultiplex the two streams from one device file. Grants are bursty and bounded, so neither source can starve the other.

## Interface
- BURST_MAX, 16: maximum words accepted per grant before the arbiter re-arbitrates; legal range 1..31.
- TAG_GS, 8'h47: tag placed in bits [31:24] for GS words.
- TAG_RN, 8'h52: tag placed in bits [31:24] for RN words.

- iClk  in  1  `bus_clk`; the only clock.
- iReset  in  1  synchronous, active-high reset; driven from `user_w_fpga_reset_open`.
- iGS_Valid  in  1  GS sample available.
- i16GS_Data  in  16  GS sample.
- iGS_Last  in  1  this GS sample ends its record.
- oGS_Ready  out  1  GS sample accepted this cycle when high together with iGS_Valid.
- iRN_Valid, i16RN_Data, iRN_Last, oRN_Ready: same roles and widths for the RN stream.
- iTx_Full  in  1  TX FIFO almost-full; must assert while at least 1 free slot remains.
- oTx_WriteEn  out  1  FIFO write strobe.
- o32Tx_Data  out  32  {tag[7:0], last, seq[6:0], data[15:0]}.
- o2Grant  out  2  current grant: 00 none, 01 GS, 10 RN.

## Operation
- FSM states:
  - IDLE: no grant.
  - GNT_GS: GS holds the write port.
  - GNT_RN: RN holds the write port.
- Arbitration happens only in IDLE, registered:
  - only one valid → grant that source;
  - both valid → grant the source opposite the round-robin pointer's last-served source;
  - neither valid → stay in IDLE.
- The pointer updates to the granted source on every grant. After reset it points at RN, so GS wins the first tie.
- Ready logic: oX_Ready = (state == GNT_X) && !iTx_Full. A transfer occurs when Valid and Ready are both high.
- Burst counter (5 bit):
  - clears on entry to a grant state;
  - increments on each transfer.
- A grant ends (next state IDLE) on any of:
  - a transfer with Last = 1;
  - a transfer that brings the burst count to BURST_MAX;
  - Valid low while granted (source withdrew).
- The sequence counter is 7-bit, one per source:
  - an emitted word carries the current value;
  - the counter increments after each transfer and wraps 127→0;
  - it clears to 0 after a transfer with Last = 1.
- Only the granted source's counter changes. Ending a grant on the burst limit or a withdrawal does not clear the counter.
- Output word: registered from the transfer cycle: {TAG, Last, seq, data}, with oTx_WriteEn = 1 for exactly one cycle per transfer.
- iTx_Full never drops an accepted word: it only blocks further transfers. The one in-flight registered write is absorbed by the mandated 1-slot margin.

## Timing
- Reset values: state IDLE; o2Grant 00; oGS_Ready 0; oRN_Ready 0; oTx_WriteEn 0; o32Tx_Data 0; both sequence counters 0; burst counter 0.
- Reset mid-grant:
  - the write registered for the next cycle is suppressed (oTx_WriteEn 0);
  - all partial-record state is discarded.
- Latency:
  - Valid rising in IDLE at cycle n → grant and Ready at n+1 (if not full);
  - a transfer at cycle t → oTx_WriteEn and data at t+1.
- Throughput: one word per cycle within a grant.
- Grant-end overhead: one IDLE cycle between consecutive grants.
- iTx_Full is sampled combinationally into Ready. Full asserting at cycle t blocks a transfer at t.
- Simultaneous events:
  - both Valids rise in the same IDLE cycle → round-robin rule;
  - Last and the burst limit on the same transfer → one grant end, and the sequence counter clears.
- o2Grant is a registered copy of the state.

## Test plan
- Reset then GS only: GS sends 3 words 16'h0001..0003, Last on the 3rd → three writes 32'h4700_0001, 32'h4701_0002, 32'h4782_0003; o2Grant 01 for 3 cycles.
- Both streams valid continuously, BURST_MAX=4, no Last → granted runs alternate GS×4, RN×4, GS×4; one idle cycle between runs; GS seq continues 4,5,6,7 in its second run.
- iTx_Full held high for 5 cycles mid-grant → Ready low for those cycles; no writes after the in-flight one; resumes with no loss or duplication; sequence contiguous.
- RN sends 130 words without Last (BURST_MAX=31) → seq field wraps 127→0 at word 129; tag 8'h52 on all words.
- iReset asserted one cycle after a GS transfer → oTx_WriteEn 0 the following cycle; the next GS word after reset carries seq 0.
- GS drops Valid after 2 words with no Last → grant released; a pending RN request is granted 2 cycles later; GS seq resumes at 2.

Source files
------------

// File: rtl/peatc_tx_arbiter.sv
// Round-robin merge of the GS and RN 16-bit sample streams into tagged 32-bit words for one host FIFO port.
// Grant one cycle after Valid in IDLE, write one cycle after transfer; iTx_Full combinationally drops Ready.
module peatc_tx_arbiter #(
    parameter int         BURST_MAX = 16,
    parameter logic [7:0] TAG_GS    = 8'h47,
    parameter logic [7:0] TAG_RN    = 8'h52
) (
    input  logic        iClk,
    input  logic        iReset,
    input  logic        iGS_Valid,
    input  logic [15:0] i16GS_Data,
    input  logic        iGS_Last,
    output logic        oGS_Ready,
    input  logic        iRN_Valid,
    input  logic [15:0] i16RN_Data,
    input  logic        iRN_Last,
    output logic        oRN_Ready,
    input  logic        iTx_Full,
    output logic        oTx_WriteEn,
    output logic [31:0] o32Tx_Data,
    output logic [1:0]  o2Grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_GS = 2'd1,
        GNT_RN = 2'd2
    } state_t;

    localparam logic [4:0] BURST_LIM = 5'(BURST_MAX);

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        ptr_rn_q, ptr_rn_d;
    logic [4:0]  burst_q, burst_d;
    logic [6:0]  gs_seq_q, gs_seq_d;
    logic [6:0]  rn_seq_q, rn_seq_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] tx_dat_q, tx_dat_d;

    logic        gs_rdy, rn_rdy;
    logic        gs_xfer, rn_xfer;

    always_comb begin
        gs_rdy  = (state_q == GNT_GS) && !iTx_Full;
        rn_rdy  = (state_q == GNT_RN) && !iTx_Full;
        gs_xfer = gs_rdy && iGS_Valid;
        rn_xfer = rn_rdy && iRN_Valid;
    end

    always_comb begin
        state_d  = state_q;
        ptr_rn_d = ptr_rn_q;
        burst_d  = burst_q;
        gs_seq_d = gs_seq_q;
        rn_seq_d = rn_seq_q;
        wr_en_d  = 1'b0;
        tx_dat_d = tx_dat_q;

        case (state_q)
            IDLE: begin
                // On a tie the pointer names the last-served source, which loses.
                if (iGS_Valid && (!iRN_Valid || ptr_rn_q)) begin
                    state_d  = GNT_GS;
                    ptr_rn_d = 1'b0;
                    burst_d  = 5'd0;
                end else if (iRN_Valid) begin
                    state_d  = GNT_RN;
                    ptr_rn_d = 1'b1;
                    burst_d  = 5'd0;
                end
            end
            GNT_GS: begin
                if (!iGS_Valid) begin
                    state_d = IDLE;
                end else if (gs_xfer) begin
                    burst_d = burst_q + 5'd1;
                    if (iGS_Last || (burst_d == BURST_LIM)) begin
                        state_d = IDLE;
                    end
                end
            end
            GNT_RN: begin
                if (!iRN_Valid) begin
                    state_d = IDLE;
                end else if (rn_xfer) begin
                    burst_d = burst_q + 5'd1;
                    if (iRN_Last || (burst_d == BURST_LIM)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The emitted word carries the pre-increment sequence number.
        if (gs_xfer) begin
            wr_en_d  = 1'b1;
            tx_dat_d = {TAG_GS, iGS_Last, gs_seq_q, i16GS_Data};
            gs_seq_d = iGS_Last ? 7'd0 : gs_seq_q + 7'd1;
        end
        if (rn_xfer) begin
            wr_en_d  = 1'b1;
            tx_dat_d = {TAG_RN, iRN_Last, rn_seq_q, i16RN_Data};
            rn_seq_d = iRN_Last ? 7'd0 : rn_seq_q + 7'd1;
        end

        grant_d = state_d;
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q  <= IDLE;
            grant_q  <= 2'b00;
            ptr_rn_q <= 1'b1;
            burst_q  <= 5'd0;
            gs_seq_q <= 7'd0;
            rn_seq_q <= 7'd0;
            wr_en_q  <= 1'b0;
            tx_dat_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_rn_q <= ptr_rn_d;
            burst_q  <= burst_d;
            gs_seq_q <= gs_seq_d;
            rn_seq_q <= rn_seq_d;
            wr_en_q  <= wr_en_d;
            tx_dat_q <= tx_dat_d;
        end
    end

    assign oGS_Ready   = gs_rdy;
    assign oRN_Ready   = rn_rdy;
    assign oTx_WriteEn = wr_en_q;
    assign o32Tx_Data  = tx_dat_q;
    assign o2Grant     = grant_q;

endmodule

// File: tb/tb_peatc_tx_arbiter.sv
// Scoreboard bench for peatc_tx_arbiter: per-source record queues feed the DUT, a reference model predicts words.
module tb_peatc_tx_arbiter;

    localparam int BMAX = 4;

    logic        clk = 1'b0;
    logic        iReset;
    logic        iGS_Valid, iGS_Last, oGS_Ready;
    logic [15:0] i16GS_Data;
    logic        iRN_Valid, iRN_Last, oRN_Ready;
    logic [15:0] i16RN_Data;
    logic        iTx_Full;
    logic        oTx_WriteEn;
    logic [31:0] o32Tx_Data;
    logic [1:0]  o2Grant;

    always #5 clk = ~clk;

    peatc_tx_arbiter #(.BURST_MAX(BMAX)) dut (
        .iClk        (clk),
        .iReset      (iReset),
        .iGS_Valid   (iGS_Valid),
        .i16GS_Data  (i16GS_Data),
        .iGS_Last    (iGS_Last),
        .oGS_Ready   (oGS_Ready),
        .iRN_Valid   (iRN_Valid),
        .i16RN_Data  (i16RN_Data),
        .iRN_Last    (iRN_Last),
        .oRN_Ready   (oRN_Ready),
        .iTx_Full    (iTx_Full),
        .oTx_WriteEn (oTx_WriteEn),
        .o32Tx_Data  (o32Tx_Data),
        .o2Grant     (o2Grant)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [16:0] gs_src[$];
    logic [16:0] rn_src[$];
    bit gs_hold  = 0;
    bit rn_hold  = 0;
    bit full_ctl = 0;
    bit prev_xfer = 0;

    // Reference state: owner 0 none / 1 GS / 2 RN, last-served source, words in current grant.
    int m_owner;
    int m_last_served;
    int m_words;
    int m_seq[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner       = 0;
        m_last_served = 2;
        m_words       = 0;
        m_seq[0]      = 0;
        m_seq[1]      = 0;
    endtask

    task automatic model_advance();
        bit v, l;
        logic [15:0] d;
        int s, nxt;
        if (m_owner == 0) begin
            nxt = 0;
            if (iGS_Valid && iRN_Valid) nxt = (m_last_served == 1) ? 2 : 1;
            else if (iGS_Valid)         nxt = 1;
            else if (iRN_Valid)         nxt = 2;
            if (nxt != 0) begin
                m_last_served = nxt;
                m_words       = 0;
            end
            m_owner = nxt;
        end else begin
            s = m_owner - 1;
            if (s == 0) begin v = iGS_Valid; l = iGS_Last; d = i16GS_Data; end
            else        begin v = iRN_Valid; l = iRN_Last; d = i16RN_Data; end
            if (!v) begin
                m_owner = 0;
            end else if (!full_ctl) begin
                exp_q.push_back({(s == 0) ? 8'h47 : 8'h52, l, 7'(m_seq[s]), d});
                prev_xfer = 1;
                m_seq[s]  = l ? 0 : (m_seq[s] + 1) % 128;
                m_words++;
                if (s == 0) void'(gs_src.pop_front());
                else        void'(rn_src.pop_front());
                if (l || m_words == BMAX) m_owner = 0;
            end
        end
    endtask

    task automatic step(input bit rst);
        @(negedge clk);
        iReset    = rst;
        iGS_Valid = (gs_src.size() > 0) && !gs_hold;
        if (iGS_Valid) {iGS_Last, i16GS_Data} = gs_src[0];
        else begin i16GS_Data = 16'($urandom); iGS_Last = 1'($urandom); end
        iRN_Valid = (rn_src.size() > 0) && !rn_hold;
        if (iRN_Valid) {iRN_Last, i16RN_Data} = rn_src[0];
        else begin i16RN_Data = 16'($urandom); iRN_Last = 1'($urandom); end
        iTx_Full = full_ctl;
        #1;
        chk("grant",    {30'd0, o2Grant},     32'(m_owner));
        chk("gs_ready", {31'd0, oGS_Ready},   {31'd0, (m_owner == 1) && !full_ctl});
        chk("rn_ready", {31'd0, oRN_Ready},   {31'd0, (m_owner == 2) && !full_ctl});
        chk("wr_en",    {31'd0, oTx_WriteEn}, {31'd0, prev_xfer});
        prev_xfer = 0;
        if (rst) model_reset();
        else     model_advance();
    endtask

    task automatic push_words(input int src, input int n, input logic [15:0] base, input bit last_end);
        for (int i = 0; i < n; i++) begin
            if (src == 0) gs_src.push_back({last_end && (i == n - 1), 16'(base + 16'(i))});
            else          rn_src.push_back({last_end && (i == n - 1), 16'(base + 16'(i))});
        end
    endtask

    task automatic drain();
        int n = 0;
        gs_hold = 0; rn_hold = 0; full_ctl = 0;
        while ((gs_src.size() > 0 || rn_src.size() > 0 || m_owner != 0) && n < 2000) begin
            step(0);
            n++;
        end
        step(0);
        step(0);
        if (n >= 2000) begin
            checks++; failures++;
            $display("FAIL drain: still busy after %0d cycles, required idle", n);
        end
    endtask

    // Monitor: every DUT write must match the oldest predicted word.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (oTx_WriteEn === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL tx_word: unexpected write %h, required none", o32Tx_Data);
                end else begin
                    chk("tx_word", o32Tx_Data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        iReset = 1'b1;
        iGS_Valid = 0; iGS_Last = 0; i16GS_Data = '0;
        iRN_Valid = 0; iRN_Last = 0; i16RN_Data = '0;
        iTx_Full = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant",    {30'd0, o2Grant},     32'd0);
        chk("rst_gs_ready", {31'd0, oGS_Ready},   32'd0);
        chk("rst_rn_ready", {31'd0, oRN_Ready},   32'd0);
        chk("rst_wr_en",    {31'd0, oTx_WriteEn}, 32'd0);
        chk("rst_data",     o32Tx_Data,           32'd0);
        model_reset();

        // Both streams continuous, no Last: alternating bursts, GS first.
        push_words(0, 12, 16'h1000, 0);
        push_words(1, 12, 16'h2000, 0);
        drain();

        // GS record of three words with Last on the third.
        push_words(0, 3, 16'h0001, 1);
        drain();

        // Full held for five cycles mid-grant.
        push_words(0, 6, 16'h3000, 0);
        step(0); step(0);
        full_ctl = 1;
        repeat (5) step(0);
        full_ctl = 0;
        drain();

        // RN long run: sequence wraps past 127.
        push_words(1, 130, 16'h4000, 0);
        drain();

        // Reset one cycle after a GS transfer, GS still offering.
        push_words(0, 5, 16'h5000, 1);
        step(0); step(0);
        step(1);
        drain();

        // GS withdraws after two words while RN waits.
        push_words(0, 4, 16'h6000, 1);
        push_words(1, 2, 16'h7000, 1);
        step(0);
        step(0); step(0);
        gs_hold = 1;
        repeat (4) step(0);
        gs_hold = 0;
        drain();

        // Randomized traffic with withdrawals, full and occasional reset.
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 2) == 0 && gs_src.size() < 8)
                gs_src.push_back({$urandom_range(0, 7) == 0, 16'($urandom)});
            if ($urandom_range(0, 2) == 0 && rn_src.size() < 8)
                rn_src.push_back({$urandom_range(0, 7) == 0, 16'($urandom)});
            gs_hold  = ($urandom_range(0, 9) == 0);
            rn_hold  = ($urandom_range(0, 9) == 0);
            full_ctl = ($urandom_range(0, 5) == 0);
            step($urandom_range(0, 399) == 0);
        end
        drain();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
